// File: rtl/map_pkg.sv
// Shared tile-map definitions: grid geometry, cell/sprite widths and the access FSM encoding.
// Pure declarations; no latency or flow control of its own.
package map_pkg;

    localparam int GRID_W   = 20;
    localparam int GRID_H   = 15;
    localparam int CELLS    = GRID_W * GRID_H;
    localparam int ADDR_W   = 9;
    localparam int SPRITE_W = 4;
    localparam int OPS_W    = 4;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_ARB    = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_RESP   = 2'd3
    } map_state_t;

    function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(CELLS);
    endfunction

    // Row-major cell index used by the world logic when it builds addresses.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] x, input logic [3:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/frame_window.sv
// Frame-update window: opens the cycle after each vga_vs falling edge, closes on timeout or op budget.
// Latency: window_open one cycle after the edge; no backpressure, the issue pulse is always accepted.
module frame_window
    import map_pkg::*;
#(
    parameter int WINDOW_LEN = 60000,
    parameter int MAX_OPS    = 8
) (
    input  logic             clock_50,
    input  logic             reset_key,
    input  logic             vga_vs,
    input  logic             issue,
    output logic             window_open,
    output logic             win_start,
    output logic [OPS_W-1:0] ops_count
);

    localparam int               WIN_W   = $clog2(WINDOW_LEN + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [OPS_W-1:0] OPS_MAX  = OPS_W'(MAX_OPS);

    logic             vs_q;
    logic             vs_fall;
    logic [WIN_W-1:0] win_cnt;
    logic [OPS_W-1:0] ops_next;

    assign vs_fall  = vs_q & ~vga_vs;
    assign ops_next = (issue && ops_count != OPS_MAX) ? ops_count + OPS_W'(1) : ops_count;

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            vs_q        <= 1'b1;
            win_cnt     <= '0;
            ops_count   <= '0;
            window_open <= 1'b0;
            win_start   <= 1'b0;
        end else begin
            vs_q      <= vga_vs;
            win_start <= vs_fall;
            // A new edge restarts the window even if one is already open.
            if (vs_fall) begin
                window_open <= 1'b1;
                win_cnt     <= '0;
                ops_count   <= '0;
            end else begin
                ops_count <= ops_next;
                if (window_open) begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (win_cnt == WIN_LAST || ops_next == OPS_MAX) begin
                        window_open <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/map_access_arbiter.sv
// Arbitrates robot (req0) and cursor (req1) access to the single-port tile-map RAM inside the frame window.
// Latency: gnt at ARB+1, rvalid at ARB+2, one access per 3 cycles; requests are held until granted.
module map_access_arbiter
    import map_pkg::*;
#(
    parameter int WINDOW_LEN = 60000,
    parameter int MAX_OPS    = 8
) (
    input  logic                clock_50,
    input  logic                reset_key,
    input  logic                vga_vs,
    input  logic                mode,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [SPRITE_W-1:0] wdata0,
    input  logic [SPRITE_W-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [SPRITE_W-1:0] rdata,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [SPRITE_W-1:0] mem_wdata,
    input  logic [SPRITE_W-1:0] mem_rdata,
    output logic                window_open,
    output logic [OPS_W-1:0]    ops_count
);

    map_state_t          state;
    logic                win_start;
    logic                tie_seen;
    logic                last_gnt;
    logic                winner;
    logic                rd_q;
    logic                oor_q;

    logic                tie;
    logic                first_tie;
    logic                pick1;
    logic                sel_we;
    logic                sel_ok;
    logic [ADDR_W-1:0]   sel_addr;
    logic [SPRITE_W-1:0] sel_wdata;

    frame_window #(
        .WINDOW_LEN (WINDOW_LEN),
        .MAX_OPS    (MAX_OPS)
    ) u_frame_window (
        .clock_50    (clock_50),
        .reset_key   (reset_key),
        .vga_vs      (vga_vs),
        .issue       (state == ST_ISSUE),
        .window_open (window_open),
        .win_start   (win_start),
        .ops_count   (ops_count)
    );

    // last_gnt: 0 = robot granted last, 1 = cursor. mode=1 prefers robot on the first tie of a window.
    always_comb begin
        tie       = req0 & req1;
        first_tie = ~tie_seen | win_start;
        if (tie) begin
            pick1 = first_tie ? ~mode : ~last_gnt;
        end else begin
            pick1 = req1;
        end
        sel_addr  = pick1 ? addr1  : addr0;
        sel_we    = pick1 ? we1    : we0;
        sel_wdata = pick1 ? wdata1 : wdata0;
        sel_ok    = addr_in_map(sel_addr);
    end

    // Out-of-range reads return zero rather than whatever the RAM holds past the map.
    assign rdata = ((rvalid0 | rvalid1) && !oor_q) ? mem_rdata : '0;

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            state     <= ST_CLOSED;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            tie_seen  <= 1'b0;
            last_gnt  <= 1'b0;
            winner    <= 1'b0;
            rd_q      <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err     <= 1'b0;
            mem_we  <= 1'b0;
            if (win_start) begin
                tie_seen <= 1'b0;
            end
            case (state)
                ST_CLOSED: begin
                    if (window_open) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!window_open) begin
                        state <= ST_CLOSED;
                    end else if (req0 || req1) begin
                        gnt0      <= ~pick1;
                        gnt1      <= pick1;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we & sel_ok;
                        err       <= ~sel_ok;
                        winner    <= pick1;
                        last_gnt  <= pick1;
                        rd_q      <= ~sel_we;
                        oor_q     <= ~sel_ok;
                        if (tie) begin
                            tie_seen <= 1'b1;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rvalid0 <= rd_q & ~winner;
                    rvalid1 <= rd_q & winner;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_ARB;
                end
                default: begin
                    state <= ST_CLOSED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter with a behavioural 1-cycle-latency map RAM.
module tb_map_access_arbiter;

    localparam int WL = 100;

    logic       clock_50 = 1'b0;
    logic       reset_key, vga_vs, mode;
    logic       req0, req1, we0, we1;
    logic [8:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, err, mem_we, window_open;
    logic [3:0] rdata, mem_wdata, mem_rdata, ops_count;
    logic [8:0] mem_addr;

    logic [3:0] ram [512];
    logic       preload;

    int checks = 0;
    int errors = 0;

    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram[i] <= 4'h0;
            ram[5]   <= 4'h7;
            ram[299] <= 4'h3;
            ram[300] <= 4'hC;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    map_access_arbiter #(.WINDOW_LEN(WL), .MAX_OPS(8)) dut (
        .clock_50(clock_50), .reset_key(reset_key), .vga_vs(vga_vs), .mode(mode),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .window_open(window_open), .ops_count(ops_count)
    );

    typedef struct packed {
        logic md;
        logic r0; logic w0; logic [8:0] a0; logic [3:0] d0;
        logic r1; logic w1; logic [8:0] a1; logic [3:0] d1;
        logic eg0; logic eg1; logic eerr; logic emwe;
        logic [8:0] eaddr; logic [3:0] ewd;
        logic erv0; logic erv1; logic [3:0] erd;
    } vec_t;

    typedef struct packed {
        logic to; logic [3:0] waits;
        logic g0; logic g1; logic er; logic mwe;
        logic [8:0] maddr; logic [3:0] mwd;
        logic rv0; logic rv1; logic [3:0] rd; logic [3:0] ops; logic mwe_after;
    } obs_t;

    function automatic vec_t mk(
        input logic md,
        input logic r0, input logic w0, input logic [8:0] a0, input logic [3:0] d0,
        input logic r1, input logic w1, input logic [8:0] a1, input logic [3:0] d1,
        input logic eg0, input logic eg1, input logic eerr, input logic emwe,
        input logic [8:0] eaddr, input logic [3:0] ewd,
        input logic erv0, input logic erv1, input logic [3:0] erd);
        vec_t v;
        v.md = md; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.eerr = eerr; v.emwe = emwe;
        v.eaddr = eaddr; v.ewd = ewd; v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic vs_fall();
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
        tick();
    endtask

    task automatic do_txn(input vec_t v, output obs_t o);
        mode = v.md;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        o = '0;
        o.to = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (gnt0 || gnt1) begin
                o.to = 1'b0;
                o.waits = 4'(k);
                break;
            end
        end
        o.g0 = gnt0; o.g1 = gnt1; o.er = err; o.mwe = mem_we;
        o.maddr = mem_addr; o.mwd = mem_wdata;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        o.rv0 = rvalid0; o.rv1 = rvalid1; o.rd = rdata; o.ops = ops_count; o.mwe_after = mem_we;
        tick();
    endtask

    vec_t vecs [8];
    vec_t rd5;
    obs_t o;
    int   n, last_t, seen, wopen;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 1,0,9'd5,4'h0,   0,0,9'd0,4'h0,   1,0,0,0, 9'd5,  4'h0, 1,0,4'h7);
        vecs[1] = mk(0, 0,0,9'd0,4'h0,   1,1,9'd10,4'h9,  0,1,0,1, 9'd10, 4'h9, 0,0,4'h0);
        vecs[2] = mk(0, 0,0,9'd0,4'h0,   1,0,9'd10,4'h0,  0,1,0,0, 9'd10, 4'h0, 0,1,4'h9);
        vecs[3] = mk(0, 1,0,9'd5,4'h0,   1,0,9'd299,4'h0, 0,1,0,0, 9'd299,4'h0, 0,1,4'h3);
        vecs[4] = mk(0, 1,0,9'd5,4'h0,   1,0,9'd299,4'h0, 1,0,0,0, 9'd5,  4'h0, 1,0,4'h7);
        vecs[5] = mk(1, 0,0,9'd0,4'h0,   1,1,9'd300,4'hF, 0,1,1,0, 9'd300,4'hF, 0,0,4'h0);
        vecs[6] = mk(1, 1,0,9'd300,4'h0, 0,0,9'd0,4'h0,   1,0,1,0, 9'd300,4'h0, 1,0,4'h0);
        vecs[7] = mk(1, 0,0,9'd0,4'h0,   1,0,9'd299,4'h0, 0,1,0,0, 9'd299,4'h0, 0,1,4'h3);
        rd5     = mk(1, 1,0,9'd5,4'h0,   0,0,9'd0,4'h0,   1,0,0,0, 9'd5,  4'h0, 1,0,4'h7);

        reset_key = 1'b1; vga_vs = 1'b1; mode = 1'b0; preload = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #2 reset_key = 1'b0;
        tick(); tick();
        chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, err, mem_we, window_open,
                              ops_count, rdata, mem_wdata, mem_addr}, 32'h0);
        preload = 1'b0;
        reset_key = 1'b1;

        // No vertical-sync edge yet: requests must be ignored.
        req0 = 1'b1; addr0 = 9'd5;
        seen = 0; wopen = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (gnt0 || gnt1) seen++;
            if (window_open) wopen++;
        end
        chk("no_edge_grants", seen, 0);
        chk("no_edge_window", wopen, 0);
        req0 = 1'b0;

        vs_fall();
        chk("open_after_edge", window_open, 1);
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], o);
            chk($sformatf("v%0d_timeout", i), o.to, 0);
            chk($sformatf("v%0d_latency", i), o.waits, 1);
            chk($sformatf("v%0d_gnt", i), {o.g0, o.g1}, {vecs[i].eg0, vecs[i].eg1});
            chk($sformatf("v%0d_err", i), o.er, vecs[i].eerr);
            chk($sformatf("v%0d_mem_we", i), o.mwe, vecs[i].emwe);
            chk($sformatf("v%0d_mem_addr", i), o.maddr, vecs[i].eaddr);
            if (vecs[i].emwe) chk($sformatf("v%0d_mem_wdata", i), o.mwd, vecs[i].ewd);
            chk($sformatf("v%0d_rvalid", i), {o.rv0, o.rv1}, {vecs[i].erv0, vecs[i].erv1});
            if (vecs[i].erv0 || vecs[i].erv1) chk($sformatf("v%0d_rdata", i), o.rd, vecs[i].erd);
            chk($sformatf("v%0d_ops", i), o.ops, i + 1);
            chk($sformatf("v%0d_we_resp", i), o.mwe_after, 0);
        end
        chk("budget_closes_window", window_open, 0);
        chk("budget_ops_saturated", ops_count, 8);
        chk("oor_write_ram_intact", ram[300], 4'hC);

        // Both requesters held: alternate from the mode-preferred robot, exactly 8 grants.
        mode = 1'b1;
        req0 = 1; we0 = 1; addr0 = 9'd1; wdata0 = 4'h1;
        req1 = 1; we1 = 1; addr1 = 9'd2; wdata1 = 4'h2;
        vs_fall();
        n = 0; last_t = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (gnt0 || gnt1) begin
                n++;
                chk($sformatf("alt%0d_who", n), {gnt0, gnt1}, (n % 2 == 1) ? 2'b10 : 2'b01);
                if (n > 1) chk($sformatf("alt%0d_spacing", n), t - last_t, 3);
                last_t = t;
            end
        end
        req0 = 0; req1 = 0;
        chk("alt_grant_count", n, 8);
        chk("alt_window_closed", window_open, 0);
        chk("alt_ram1", ram[1], 4'h1);
        chk("alt_ram2", ram[2], 4'h2);

        // Re-trigger while open after five accesses.
        vs_fall();
        for (int i = 0; i < 5; i++) do_txn(rd5, o);
        chk("retrig_ops_before", ops_count, 5);
        chk("retrig_open_before", window_open, 1);
        vs_fall();
        chk("retrig_ops_cleared", ops_count, 0);
        chk("retrig_still_open", window_open, 1);
        req0 = 1; we0 = 0; addr0 = 9'd5;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (gnt0) n++;
        end
        req0 = 0;
        chk("retrig_grants", n, 8);

        // Timeout with no traffic.
        vga_vs = 1'b0;
        tick();
        chk("timeout_opened", window_open, 1);
        vga_vs = 1'b1;
        n = 1;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (!window_open) break;
            n++;
        end
        chk("timeout_length", n, WL);
        req0 = 1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (gnt0) seen++;
        end
        req0 = 0;
        chk("timeout_no_grant", seen, 0);

        // Reset during ISSUE of a read.
        vs_fall();
        req0 = 1; we0 = 0; addr0 = 9'd5;
        tick();
        chk("rst_issue_gnt", gnt0, 1);
        reset_key = 1'b0;
        #1;
        chk("rst_outputs", {gnt0, gnt1, rvalid0, rvalid1, err, mem_we, window_open,
                            ops_count, rdata, mem_wdata, mem_addr}, 32'h0);
        tick();
        reset_key = 1'b1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (rvalid0 || rvalid1 || gnt0 || gnt1) seen++;
        end
        chk("rst_no_activity", seen, 0);
        vs_fall();
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (gnt0) begin
                seen = 1;
                break;
            end
        end
        req0 = 0;
        chk("rst_regrant_after_edge", seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
Shares the single-port tile-map RAM (20x15 cells, 4-bit sprite codes) between two requesters. Requester 0 is the robot engine (autonomous moves). Requester 1 is the cursor editor (gamepad edits).
Accesses are only issued inside a frame-update window that opens on each vertical-sync falling edge, so map contents never change mid-frame. The block sits between the world logic and the map RAM, in the clock_50 domain alongside vga_sync.

Parameters:
CELLS, 300, number of valid map cells (20x15); addresses >= CELLS are illegal
ADDR_W, 9, cell address width
SPRITE_W, 4, sprite code width
WINDOW_LEN, 60000, window duration in clock_50 cycles, counted from the window opening
MAX_OPS, 8, maximum granted accesses per window

Ports:
clock_50  in  1  system clock, 50 MHz; the only clock
reset_key  in  1  asynchronous active-low reset
vga_vs  in  1  vertical sync from vga_sync, active low, same clock domain
mode  in  1  0 = manual, 1 = auto; selects the tie-break preference
req0, req1  in  1 each  access request; held until gnt
we0, we1  in  1 each  1 = write, 0 = read
addr0, addr1  in  ADDR_W each  cell address
wdata0, wdata1  in  SPRITE_W each  write data
gnt0, gnt1  out  1 each  one-cycle grant pulse
rvalid0, rvalid1  out  1 each  one-cycle read-data-valid pulse
rdata  out  SPRITE_W  read data; meaningful only while an rvalid is high
err  out  1  one-cycle pulse on a granted out-of-range access
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  SPRITE_W  RAM write data
mem_rdata  in  SPRITE_W  RAM synchronous read data, 1-cycle latency
window_open  out  1  high while the update window is open
ops_count  out  4  accesses granted in the current window

Behaviour:
Reset
- Asynchronous; all outputs go to 0.
- FSM enters CLOSED; counters clear; vs_q is set to 1.
- Asserting reset mid-operation drops any in-flight access; no rvalid follows.

Window
- vs_q holds the previous cycle's vga_vs. A falling edge is vs_q=1 and vga_vs=0.
- A falling edge sets window_open=1 in the next cycle and clears the window counter and ops_count.
- The window closes when the window counter reaches WINDOW_LEN-1 or ops_count reaches MAX_OPS.
- A falling edge while the window is already open restarts the window: both counters clear.
- An in-flight access always completes, even after the window closes.

FSM (CLOSED, ARB, ISSUE, RESP)
- CLOSED: no grants. Moves to ARB when the window opens.
- ARB (cycle N): samples req0 and req1.
  - Neither request, or window closed: stays in ARB, or returns to CLOSED if the window has closed.
  - One request: that requester wins.
  - Both requesting: round-robin on the last-granted requester. The first tie in each window goes to the mode-preferred requester (mode=1 prefers robot/req0, mode=0 prefers cursor/req1).
- ISSUE (cycle N+1):
  - Winner's gnt pulses high.
  - mem_addr, mem_we and mem_wdata are driven from the winner's inputs as registered at N. mem_we is high for this cycle only.
  - ops_count increments.
- RESP (cycle N+2):
  - For a read, the winner's rvalid pulses and rdata = mem_rdata.
  - For a write, nothing is signalled.
  - Next state is ARB at N+3. Peak throughput is one access per 3 cycles.
- Requesters must drop req by cycle N+2 to avoid being re-granted.

Out-of-range addresses (addr >= CELLS)
- Still granted and still counted in ops_count.
- mem_we is forced to 0; err pulses in ISSUE.
- A read returns rdata=0 with rvalid in RESP.

Other rules
- Outside ISSUE, mem_we is 0 and mem_addr/mem_wdata hold their last values.
- ops_count saturates at MAX_OPS.
- mode changes take effect at the next ARB.

Decomposition:
- Shared package map_pkg: CELLS, ADDR_W, SPRITE_W, grid dimensions 20 and 15, and the FSM state encoding (shared with world).
- One sub-module, frame_window: vs edge detect, window counter, ops counter, window_open output. The grant FSM stays in the top of this block.

Test Plan:
- Reset released, no vga_vs edge, req0=1 -> gnt0 never asserts; window_open=0.
- vga_vs falls, req0 read addr 5 with RAM[5]=4'h7 -> gnt0 pulses at ARB+1; rvalid0 pulses 2 cycles after the ARB cycle with rdata=4'h7; ops_count=1.
- mode=1, req0 and req1 both held, writing addrs 1 and 2 -> grants alternate gnt0, gnt1, gnt0…; exactly MAX_OPS=8 grants, then window_open=0.
- req1 write addr 300 wdata 4'hF -> gnt1 and err pulse; mem_we stays 0; the RAM is unchanged.
- Second vga_vs falling edge while window open with ops_count=5 -> ops_count returns to 0 and a further 8 grants are allowed.
- reset_key low during ISSUE of a read -> all outputs go to 0 immediately and no rvalid follows; after release, the block waits for the next vga_vs edge.
